// File: rtl/fetch_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_pkg;

  localparam int unsigned AddrW  = 32;
  localparam int unsigned InstrW = 32;

  localparam logic [6:0]        OP_B      = 7'b1100000;
  localparam logic [6:0]        OP_BR     = 7'b1100010;
  localparam logic [InstrW-1:0] NOP_INSTR = 32'hC800_0000;

  typedef struct packed {
    logic [AddrW-1:0]  pc;
    logic [InstrW-1:0] instr;
  } entry_t;

  // Signed word offset to a byte offset.
  function automatic logic [AddrW-1:0] word_offset(input logic [15:0] rel);
    return {{(AddrW - 18){rel[15]}}, rel, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush overrides push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  entry_t                     push_entry_i,
  input  logic                       pop_i,
  output logic [$clog2(Depth):0]     count_o,
  output entry_t                     head_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_push  = push_i && !flush_i;
    do_pop   = pop_i && !flush_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch_queue.sv
// Fetch stage with a DEPTH-entry prefetch queue, early B/BR resolution and ID redirect.
module if_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = AddrW,
  parameter int unsigned         INSTR_W  = InstrW,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [INSTR_W-1:0]  NOP      = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic [INSTR_W-1:0] im_data,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic [15:0]        redirect_rel,
  output logic [2:0]         br_addr,
  input  logic [31:0]        br_value,
  input  logic               wb_en,
  input  logic [2:0]         wb_addr,
  input  logic [31:0]        wb_value
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [CntW-1:0]   count;
  entry_t            head, push_entry;
  logic [6:0]        opcode;
  logic              resp_valid, is_b, is_br, push, pop;
  logic [ADDR_W-1:0] br_base, resp_off;

  always_comb begin
    opcode     = im_data[31:25];
    resp_valid = inflight_q && !redirect_valid;
    is_b       = resp_valid && (opcode == OP_B);
    is_br      = resp_valid && (opcode == OP_BR);
    br_addr    = inflight_q ? im_data[24:22] : 3'd0;
    br_base    = (wb_en && (wb_addr == br_addr)) ? ADDR_W'(wb_value) : ADDR_W'(br_value);
    resp_off   = ADDR_W'(word_offset(im_data[15:0]));

    // Credit counts the in-flight response so a push can never hit a full queue.
    im_req = !rst && !redirect_valid && !is_b && !is_br &&
             ((count + CntW'(inflight_q)) < CntW'(DEPTH));

    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc + ADDR_W'(word_offset(redirect_rel));
    else if (is_b)       fetch_pc_d = inflight_pc_q + resp_off;
    else if (is_br)      fetch_pc_d = br_base + resp_off;
    else if (im_req)     fetch_pc_d = fetch_pc_q + ADDR_W'(4);

    inflight_d    = im_req;
    inflight_pc_d = im_req ? fetch_pc_q : inflight_pc_q;

    push       = resp_valid && !is_b && !is_br;
    push_entry = '{pc: AddrW'(inflight_pc_q), instr: InstrW'(im_data)};
    pop        = id_valid && id_ready && !redirect_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  fetch_queue #(
    .Depth (DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (redirect_valid),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head)
  );

  always_comb begin
    im_addr  = fetch_pc_q;
    id_valid = (count != '0);
    id_instr = id_valid ? INSTR_W'(head.instr) : NOP;
    id_pc    = id_valid ? ADDR_W'(head.pc) : '0;
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: vector table, directed corner cases, random run vs. queue model.
module tb_if_prefetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        im_req, id_valid, id_ready, redirect_valid, wb_en;
  logic [31:0] im_addr, im_data, id_instr, id_pc, redirect_pc, br_value, wb_value;
  logic [15:0] redirect_rel;
  logic [2:0]  br_addr, wb_addr;

  logic [31:0] rf   [8];
  logic [31:0] imem [64];

  assign br_value = rf[br_addr];

  if_prefetch_queue #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .NOP      (32'hC800_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_rel   (redirect_rel),
    .br_addr        (br_addr),
    .br_value       (br_value),
    .wb_en          (wb_en),
    .wb_addr        (wb_addr),
    .wb_value       (wb_value)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of fetched entries, fetch PC, one outstanding request.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_pc, m_ipc;
  bit          m_infl;
  bit          last_req;
  logic [31:0] last_addr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [2:0]  s_br;

  task automatic do_reset();
    rst = 1'b1;
    id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; redirect_rel = '0;
    wb_en = 1'b0; wb_addr = '0; wb_value = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); m_pc = 32'h0; m_ipc = 32'h0; m_infl = 1'b0; last_req = 1'b0;
  endtask

  // Called at posedge+1 with this cycle's inputs set; returns at the next posedge+1.
  task automatic tick();
    logic [6:0]  opc;
    logic [2:0]  ridx;
    bit          resp, is_b, is_br, exp_req, exp_valid;
    int          off;
    logic [31:0] base;
    im_data = last_req ? imem[last_addr[7:2]] : $urandom;
    #1;
    s_req = im_req; s_addr = im_addr; s_valid = id_valid; s_pc = id_pc;
    s_instr = id_instr; s_br = br_addr;

    opc       = im_data[31:25];
    ridx      = im_data[24:22];
    resp      = m_infl && !redirect_valid;
    is_b      = resp && (opc == OP_B);
    is_br     = resp && (opc == OP_BR);
    exp_req   = (mq.size() + int'(m_infl) < DEPTH) && !redirect_valid && !is_b && !is_br;
    exp_valid = (mq.size() != 0);
    check("im_req", 32'(im_req), 32'(exp_req));
    check("im_addr", im_addr, m_pc);
    check("id_valid", 32'(id_valid), 32'(exp_valid));
    check("id_instr", id_instr, exp_valid ? mq[0].instr : NOP_INSTR);
    check("id_pc", id_pc, exp_valid ? mq[0].pc : 32'h0);
    if (is_br) check("br_addr", 32'(br_addr), 32'(ridx));
    check("count_bound", 32'(dut.u_queue.count_o <= DEPTH), 32'h1);

    if (redirect_valid) begin
      mq.delete();
      off  = int'($signed(redirect_rel));
      m_pc = redirect_pc + 32'(off * 4);
    end else begin
      if (exp_valid && id_ready) void'(mq.pop_front());
      off = int'($signed(im_data[15:0]));
      if (is_b) begin
        m_pc = m_ipc + 32'(off * 4);
      end else if (is_br) begin
        base = (wb_en && wb_addr == ridx) ? wb_value : rf[ridx];
        m_pc = base + 32'(off * 4);
      end else if (resp) begin
        mq.push_back('{pc: m_ipc, instr: im_data});
      end
    end
    m_infl = exp_req;
    if (exp_req) begin
      m_ipc = m_pc;
      m_pc  = m_pc + 32'd4;
    end

    last_req = im_req; last_addr = im_addr;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rst_before;
    bit          ready;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] b_word, br_word;
  logic [15:0] imm;

  initial begin
    im_data = '0;
    for (int i = 0; i < 8; i++) rf[i] = 32'h0;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0001_0000 + i;

    // Sequential fetch, then backpressure and resume.
    vecs.push_back('{1, 1, 1, 32'h00, 0, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h04, 0, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h08, 1, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h0C, 1, 32'h4});
    vecs.push_back('{0, 1, 1, 32'h10, 1, 32'h8});
    vecs.push_back('{1, 0, 1, 32'h00, 0, 32'h0});
    vecs.push_back('{0, 0, 1, 32'h04, 0, 32'h0});
    vecs.push_back('{0, 0, 1, 32'h08, 1, 32'h0});
    vecs.push_back('{0, 0, 1, 32'h0C, 1, 32'h0});
    vecs.push_back('{0, 0, 0, 32'h10, 1, 32'h0});
    vecs.push_back('{0, 0, 0, 32'h10, 1, 32'h0});
    vecs.push_back('{0, 1, 0, 32'h10, 1, 32'h0});
    vecs.push_back('{0, 1, 1, 32'h10, 1, 32'h4});
    vecs.push_back('{0, 1, 1, 32'h14, 1, 32'h8});
    vecs.push_back('{0, 1, 1, 32'h18, 1, 32'hC});
    vecs.push_back('{0, 1, 1, 32'h1C, 1, 32'h10});
    vecs.push_back('{0, 1, 1, 32'h20, 1, 32'h14});

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) do_reset();
      id_ready = vecs[i].ready;
      tick();
      check("vec_req", 32'(s_req), 32'(vecs[i].exp_req));
      check("vec_addr", s_addr, vecs[i].exp_addr);
      check("vec_valid", 32'(s_valid), 32'(vecs[i].exp_valid));
      check("vec_pc", s_pc, vecs[i].exp_pc);
      if (vecs[i].exp_valid) check("vec_instr", s_instr, imem[vecs[i].exp_pc[7:2]]);
    end

    // Early B at 0x8 back to 0x0; it must never reach ID.
    b_word  = {OP_B, 9'd0, 16'hFFFE};
    imem[2] = b_word;
    do_reset(); id_ready = 1'b1;
    tick(); tick(); tick();
    tick(); check("b_stall_req", 32'(s_req), 32'h0);
    tick(); check("b_target", s_addr, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("b_not_enq", 32'(s_valid && (s_instr == b_word)), 32'h0);
    end
    imem[2] = 32'h0001_0002;

    // BR at 0x10 via r3, with and without writeback bypass.
    br_word = {OP_BR, 3'd3, 6'd0, 16'h0001};
    imem[4] = br_word;
    rf[3]   = 32'h100;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(); id_ready = 1'b1;
      wb_en = (pass == 0); wb_addr = 3'd3; wb_value = 32'h200;
      for (int i = 0; i < 5; i++) tick();
      tick();
      check("br_addr_field", 32'(s_br), 32'h3);
      check("br_stall_req", 32'(s_req), 32'h0);
      tick();
      check("br_target", s_addr, (pass == 0) ? 32'h204 : 32'h104);
    end
    imem[4] = 32'h0001_0004;
    rf[3]   = 32'h0;

    // Redirect with three queued entries plus one in flight.
    do_reset(); id_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h20; redirect_rel = 16'd4;
    tick(); check("redir_req", 32'(s_req), 32'h0);
    redirect_valid = 1'b0;
    tick(); check("redir_flush", 32'(s_valid), 32'h0);
    check("redir_target", s_addr, 32'h30);
    check("redir_issue", 32'(s_req), 32'h1);
    tick(); check("redir_drop", 32'(s_valid), 32'h0);
    tick(); check("redir_first_pc", s_pc, 32'h30);

    // Redirect in the same cycle as an early B response: redirect wins.
    imem[2] = b_word;
    do_reset(); id_ready = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40; redirect_rel = 16'd0;
    tick(); check("redir_b_req", 32'(s_req), 32'h0);
    redirect_valid = 1'b0;
    tick(); check("redir_b_target", s_addr, 32'h40);
    imem[2] = 32'h0001_0002;

    // Asynchronous reset mid-burst, away from any clock edge.
    do_reset(); id_ready = 1'b0;
    tick(); tick(); tick();
    #2; im_data = 32'hFFFF_FFFF;
    #1; rst = 1'b1;
    #1;
    check("arst_im_req", 32'(im_req), 32'h0);
    check("arst_im_addr", im_addr, 32'h0);
    check("arst_id_valid", 32'(id_valid), 32'h0);
    check("arst_id_instr", id_instr, 32'hC800_0000);
    check("arst_id_pc", id_pc, 32'h0);
    check("arst_br_addr", 32'(br_addr), 32'h0);

    // Randomised program and handshake against the model.
    for (int i = 0; i < 64; i++) begin
      imm = 16'($urandom_range(0, 15)) - 16'd8;
      case ($urandom_range(0, 9))
        0:       imem[i] = {OP_B, 9'($urandom), imm};
        1:       imem[i] = {OP_BR, 3'($urandom), 6'($urandom), imm};
        default: begin
          imem[i] = $urandom;
          if (imem[i][31:25] == OP_B || imem[i][31:25] == OP_BR) imem[i][31:25] = 7'h00;
        end
      endcase
    end
    for (int i = 0; i < 8; i++) rf[i] = $urandom & 32'hFC;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc    = $urandom & 32'hFC;
      redirect_rel   = 16'($urandom_range(0, 15)) - 16'd8;
      wb_en          = 1'($urandom);
      wb_addr        = 3'($urandom);
      wb_value       = $urandom & 32'hFC;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_prefetch_queue.md
Name: if_prefetch_queue

Overview:
- Parametrised successor to the single-entry fetch stage.
- Keeps the fetch PC and issues requests to Instruction Memory (IM), which has 1-cycle read latency.
- Buffers returned instructions and their PCs in a DEPTH-entry queue, and hands them to ID over a valid/ready handshake.
- Resolves B and BR early, in fetch. Conditional branches resolved in ID arrive as a redirect that flushes the queue and cancels any in-flight fetch.

Parameters:
- ADDR_W, 32, PC and IM address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.
- NOP, 32'hC8000000, value driven on id_instr when the queue is empty.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- im_req  out  1  IM read request this cycle
- im_addr  out  ADDR_W  IM byte address, word aligned
- im_data  in  INSTR_W  IM read data; valid the cycle after im_req
- id_valid  out  1  queue head is valid
- id_instr  out  INSTR_W  head instruction, or NOP when empty
- id_pc  out  ADDR_W  PC of the head instruction
- id_ready  in  1  ID accepts the head this cycle
- redirect_valid  in  1  taken conditional branch from ID
- redirect_pc  in  ADDR_W  PC of the branching instruction
- redirect_rel  in  16  signed word offset
- br_addr  out  3  register index for a BR read
- br_value  in  32  register file read data for br_addr
- wb_en  in  1  register file write enable
- wb_addr  in  3  register file write index
- wb_value  in  32  register file write data

Behaviour:
- Reset (asynchronous, any cycle, including mid-fetch):
  - fetch_pc=RESET_PC, count=0, inflight=0.
  - Outputs: im_req=0, im_addr=RESET_PC, id_valid=0, id_instr=NOP, id_pc=0, br_addr=0.
- Issue rule: im_req=1 when (count + inflight) < DEPTH and no redirect or early branch fires this cycle.
  - im_addr=fetch_pc. On issue: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4.
  - The PC wraps modulo 2^ADDR_W.
  - The first request goes out in the first cycle after rst deasserts.
- Response handling: the cycle after an issue, im_data is valid (inflight=1), unless the fetch was squashed.
  - Opcode im_data[31:25]==7'b1100000 (B): the instruction is not enqueued. fetch_pc<=inflight_pc + (sext(im_data[15:0])<<2).
  - Opcode 7'b1100010 (BR): the instruction is not enqueued.
    - br_addr=im_data[24:22], driven combinationally.
    - base = wb_value if (wb_en && wb_addr==br_addr), else br_value.
    - fetch_pc<=base + (sext(im_data[15:0])<<2).
  - Any other opcode: push {inflight_pc, im_data}.
- Latency: request at cycle t, data at t+1, id_valid=1 at t+2 at the earliest.
- Pop: when id_valid && id_ready, advance head. Pushing and popping in the same cycle leaves count unchanged.
- Full condition: the credit rule makes a push into a full queue impossible. Assert in the bench that count never exceeds DEPTH.
- ID redirect, which has the highest priority:
  - Flush the queue (count<=0) and squash any in-flight response; its data is dropped next cycle.
  - fetch_pc<=redirect_pc + (sext(redirect_rel)<<2).
  - im_req=0 this cycle; issue resumes next cycle.
  - A pop or an early B/BR in the same cycle is overridden.
- Early B/BR in the same cycle as a pop: the pop proceeds, and im_req=0 that cycle.
- Outputs are driven from registered queue state: id_instr and id_pc come from the head entry.

Decomposition:
- fetch_pkg holds:
  - OP_B=7'b1100000 and OP_BR=7'b1100010
  - NOP_INSTR
  - a function that sign-extends a 16-bit word offset and shifts it left by 2 to ADDR_W
  - a typedef for a queue entry {pc, instr}
- One sub-module, fetch_queue: a synchronous FIFO of DEPTH entries with push, pop, a flush that takes priority over both, count, and head outputs.

Test Plan:
- Sequential fetch: RESET_PC=0, id_ready=1, non-branch data.
  - im_addr must be 0,4,8,… on consecutive cycles.
  - First id_valid is 2 cycles after reset release, with id_pc=0, then id_pc=4.
- Backpressure: DEPTH=4, id_ready=0.
  - Exactly 4 requests (0x0–0xC), then im_req=0 and count=4.
  - Raise id_ready: resume at im_addr 0x10 with no lost or duplicated PCs.
- Early B at 0x8 with imm 0xFFFE: the next im_addr is 0x0; the B never appears on id_instr.
- BR at 0x10 with reg field 3 and imm 1:
  - With br_value=0x100 and wb_en=1, wb_addr=3, wb_value=0x200: next im_addr is 0x204.
  - With wb_en=0: next im_addr is 0x104.
- Redirect with queue holding 3 entries plus one in flight, redirect_pc=0x20, rel=4:
  - Next cycle id_valid=0.
  - The in-flight data is dropped.
  - The next im_addr is 0x30.
- Redirect coinciding with an early-B response: the redirect target wins. Assert rst mid-burst: all outputs take their reset values immediately, without waiting for a clock edge.
